// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit buffer and frame sequencer placed in front of the UART transmitter.
// Bytes written by the register block are stored in a circular FIFO. The
// sequencer launches one transmitter frame per stored byte using a
// tx_start/tx_busy handshake, keeps the byte stable for the whole frame, and
// pops it only once the frame has completed.
//
// Parameters
//   data_bits  byte width (matches the transmitter)
//   depth      FIFO entries, power of two, >= 2
//
// Ports
//   clk         in   single rising-edge clock
//   tx_rst      in   synchronous active-high reset
//   wr_en       in   write request from the register block
//   wr_data     in   byte to enqueue
//   tx_en       in   transmitter enable; low aborts the frame without a pop
//   ovf_clr     in   clears the sticky overflow flag
//   tx_busy     in   busy flag from the transmitter
//   tx_start    out  frame request to the transmitter (high in LAUNCH)
//   tx_data     out  FIFO head, registered
//   full        out  count == depth
//   empty       out  count == 0
//   count       out  number of stored entries
//   overflow    out  sticky: a write was dropped because the FIFO was full
//   frame_done  out  one-cycle pulse in the cycle the head byte is popped
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int data_bits = 8,
    parameter int depth     = 16
) (
    input  logic                   clk,
    input  logic                   tx_rst,
    input  logic                   wr_en,
    input  logic [data_bits-1:0]   wr_data,
    input  logic                   tx_en,
    input  logic                   ovf_clr,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [data_bits-1:0]   tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count,
    output logic                   overflow,
    output logic                   frame_done
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_ACTIVE,
        S_POP
    } state_e;

    logic [data_bits-1:0] mem_q [depth];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [data_bits-1:0] tx_data_q, tx_data_d;

    state_e               state_q;
    logic                 tx_start_q;
    logic                 frame_done_q;

    logic                 full_w;
    logic                 empty_w;
    logic                 wr_ok;
    logic                 pop;

    // Flags come from the registered count, so a pop in the same cycle never
    // frees a slot for a write that arrives while full.
    assign full_w  = (count_q == CNT_W'(depth));
    assign empty_w = (count_q == '0);
    assign wr_ok   = wr_en && !full_w;
    assign pop     = (state_q == S_POP);

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A dropped write takes precedence over a clear in the same cycle.
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        // The head register looks at the entry the read pointer will point
        // to next. If that entry is being written this cycle (FIFO empty, or
        // its last byte popping), forward the incoming byte.
        tx_data_d = mem_q[rd_ptr_d];
        if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
            tx_data_d = wr_data;
        end
    end

    // NOTE: storage has no reset; the pointers and count define which
    // entries are valid, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (tx_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer; tx_start and frame_done are registered alongside the
    // state so they are exactly "in LAUNCH" and "in POP".
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (tx_rst) begin
            state_q      <= S_IDLE;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            if (!tx_en) begin
                // Abort without popping: the head byte is sent again in
                // full once the transmitter is re-enabled.
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!empty_w) begin
                            state_q    <= S_LAUNCH;
                            tx_start_q <= 1'b1;
                        end
                    end
                    S_LAUNCH: begin
                        if (tx_busy) begin
                            state_q <= S_ACTIVE;
                        end else begin
                            tx_start_q <= 1'b1;
                        end
                    end
                    S_ACTIVE: begin
                        // tx_start stays low here so the transmitter cannot
                        // chain a second frame on the byte still at the head.
                        if (!tx_busy) begin
                            state_q      <= S_POP;
                            frame_done_q <= 1'b1;
                        end
                    end
                    S_POP: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule
